// File: rtl/clint_pkg.sv
// Shared constants, types and helpers for the core-local interruptor (clint_timer).
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF    = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_OFF       = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_t;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

    // Word offset within the 64 KiB window; unmapped words decode to REG_NONE.
    function automatic reg_sel_t decode_offset(input logic [13:0] word_off);
        reg_sel_t sel;
        sel = REG_NONE;
        if (word_off == CLINT_MSIP_OFF[15:2])        sel = REG_MSIP;
        if (word_off == CLINT_MTIMECMP_OFF[15:2])    sel = REG_CMP_LO;
        if (word_off == CLINT_MTIMECMP_HI_OFF[15:2]) sel = REG_CMP_HI;
        if (word_off == CLINT_MTIME_OFF[15:2])       sel = REG_TIME_LO;
        if (word_off == CLINT_MTIME_HI_OFF[15:2])    sel = REG_TIME_HI;
        return sel;
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Data-memory bus slave port of clint_timer: one request channel, one response channel.
interface clint_timer_if;
    // Handshake: a request transfers on a cycle with req_valid & req_ready, a response
    // on a cycle with rsp_valid & rsp_ready; a valid holder keeps its payload stable
    // until that transfer cycle.
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/clint_prescaler.sv
// mtime prescaler: single-cycle tick strobe once every TICK_DIV clk cycles (1..65535).
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam logic [15:0] RELOAD = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else if (cnt_q == 16'd0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign tick = (cnt_q == 16'd0);
endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime / mtimecmp / msip behind a single-outstanding bus slave.
// Optional feature macro: CLINT_MSIP_EN (msip register at offset 0x0000; otherwise msip tied 0).
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic          clk,
    input  logic          rst,
    clint_timer_if.slave  bus,
    output logic          mtip,
    output logic          msip,
    output bus_state_t    dbg_state
);
    bus_state_t  state_q, state_d;
    logic        accept;
    logic        wr_en;
    logic        in_window;
    reg_sel_t    sel;
    logic        tick;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        mtip_q;
    logic        msip_bit;
    logic [31:0] rd_word;
    logic [31:0] rsp_rdata_q;
    logic        unused_addr_bits;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= BUS_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = BUS_RESP;
                end
            end
            BUS_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    // Accesses outside the window still complete, as unmapped offsets.
    assign in_window        = (bus.req_addr[31:16] == BASE_ADDR[31:16]);
    assign sel              = in_window ? decode_offset(bus.req_addr[15:2]) : REG_NONE;
    assign wr_en            = accept & bus.req_write;
    assign unused_addr_bits = ^bus.req_addr[1:0];

    always_comb begin
        rd_word = 32'd0;
        case (sel)
            REG_MSIP:    rd_word = {31'd0, msip_bit};
            REG_CMP_LO:  rd_word = mtimecmp_q[31:0];
            REG_CMP_HI:  rd_word = mtimecmp_q[63:32];
            REG_TIME_LO: rd_word = mtime_q[31:0];
            REG_TIME_HI: rd_word = mtime_q[63:32];
            default:     rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         rsp_rdata_q <= 32'd0;
        else if (accept) rsp_rdata_q <= bus.req_write ? 32'd0 : rd_word;
    end

    assign bus.rsp_rdata = rsp_rdata_q;

    // A bus write to either half drops that cycle's increment for the whole counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q <= 64'd0;
        end else if (wr_en && sel == REG_TIME_LO) begin
            mtime_q[31:0] <= apply_wstrb(mtime_q[31:0], bus.req_wdata, bus.req_wstrb);
        end else if (wr_en && sel == REG_TIME_HI) begin
            mtime_q[63:32] <= apply_wstrb(mtime_q[63:32], bus.req_wdata, bus.req_wstrb);
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_q <= CLINT_MTIMECMP_RST;
        end else if (wr_en && sel == REG_CMP_LO) begin
            mtimecmp_q[31:0] <= apply_wstrb(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb);
        end else if (wr_en && sel == REG_CMP_HI) begin
            mtimecmp_q[63:32] <= apply_wstrb(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mtip_q <= 1'b0;
        else     mtip_q <= (mtime_q >= mtimecmp_q);
    end

`ifdef CLINT_MSIP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_bit <= 1'b0;
        end else if (wr_en && sel == REG_MSIP && bus.req_wstrb[0]) begin
            msip_bit <= bus.req_wdata[0];
        end
    end
`else
    assign msip_bit = 1'b0;
`endif

    assign mtip      = mtip_q;
    assign msip      = msip_bit;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: cycle model on the TICK_DIV=1 instance plus directed checks.
module tb_clint_timer;
  import clint_pkg::*;

`ifdef CLINT_MSIP_EN
  localparam logic MSIP_EXP = 1'b1;
`else
  localparam logic MSIP_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic mtip1, msip1, mtip4, msip4;
  bus_state_t dbg1, dbg4;

  int n_pass = 0;
  int n_checks = 0;

  clint_timer_if bus1();
  clint_timer_if bus4();

  clint_timer #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .bus(bus1.slave), .mtip(mtip1), .msip(msip1), .dbg_state(dbg1)
  );

  clint_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .mtip(mtip4), .msip(msip4), .dbg_state(dbg4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model (TICK_DIV=1 instance) ----------------
  // mtime advances once per cycle counted from reset; a bus write replaces the written
  // bytes and suppresses that cycle's advance; mtip is last cycle's (mtime >= mtimecmp).
  localparam int TB_DIV = 1;
  logic [63:0] m_time, m_cmp, n_time, n_cmp;
  logic        m_msip, n_msip, m_busy, n_busy, m_mtip;
  logic [31:0] m_rdata, n_rdata;
  int          m_cyc;
  bit          mdl_valid = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [15:0] word_off(input logic [31:0] a);
    return {a[15:2], 2'b00};
  endfunction

  always_comb begin
    n_time  = m_time + (((m_cyc % TB_DIV) == TB_DIV - 1) ? 64'd1 : 64'd0);
    n_cmp   = m_cmp;
    n_msip  = m_msip;
    n_busy  = m_busy;
    n_rdata = m_rdata;
    if (m_busy) begin
      if (bus1.rsp_ready) n_busy = 1'b0;
    end else if (bus1.req_valid) begin
      n_busy  = 1'b1;
      n_rdata = 32'd0;
      if (bus1.req_addr[31:16] == 16'h0200) begin
        if (!bus1.req_write) begin
          case (word_off(bus1.req_addr))
            16'h0000: n_rdata = {31'd0, m_msip};
            16'h4000: n_rdata = m_cmp[31:0];
            16'h4004: n_rdata = m_cmp[63:32];
            16'hBFF8: n_rdata = m_time[31:0];
            16'hBFFC: n_rdata = m_time[63:32];
            default:  n_rdata = 32'd0;
          endcase
        end else begin
          case (word_off(bus1.req_addr))
            16'h0000: if (MSIP_EXP && bus1.req_wstrb[0]) n_msip = bus1.req_wdata[0];
            16'h4000: n_cmp[31:0]  = merge(m_cmp[31:0], bus1.req_wdata, bus1.req_wstrb);
            16'h4004: n_cmp[63:32] = merge(m_cmp[63:32], bus1.req_wdata, bus1.req_wstrb);
            16'hBFF8: n_time = {m_time[63:32], merge(m_time[31:0], bus1.req_wdata, bus1.req_wstrb)};
            16'hBFFC: n_time = {merge(m_time[63:32], bus1.req_wdata, bus1.req_wstrb), m_time[31:0]};
            default: ;
          endcase
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_time <= 64'd0;
      m_cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip <= 1'b0;
      m_busy <= 1'b0;
      m_rdata <= 32'd0;
      m_mtip <= 1'b0;
      m_cyc <= 0;
      mdl_valid <= 1'b1;
    end else begin
      m_time <= n_time;
      m_cmp <= n_cmp;
      m_msip <= n_msip;
      m_busy <= n_busy;
      m_rdata <= n_rdata;
      m_mtip <= (m_time >= m_cmp);
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mdl_valid && !rst) begin
      check("cyc_req_ready", {63'd0, bus1.req_ready}, {63'd0, !m_busy});
      check("cyc_rsp_valid", {63'd0, bus1.rsp_valid}, {63'd0, m_busy});
      if (m_busy) check("cyc_rsp_rdata", {32'd0, bus1.rsp_rdata}, {32'd0, m_rdata});
      check("cyc_mtip", {63'd0, mtip1}, {63'd0, m_mtip});
      check("cyc_msip", {63'd0, msip1}, {63'd0, m_msip});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int which, input bit v, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (which == 0) begin
      bus1.req_valid = v; bus1.req_write = wr; bus1.req_addr = a; bus1.req_wdata = d; bus1.req_wstrb = s;
    end else begin
      bus4.req_valid = v; bus4.req_write = wr; bus4.req_addr = a; bus4.req_wdata = d; bus4.req_wstrb = s;
    end
  endtask

  // Called just after a clock edge; returns just after the response-handshake edge.
  task automatic bus_xfer(input int which, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata);
    int n;
    bit acc, done;
    rdata = 32'd0;
    set_req(which, 1'b1, wr, a, d, s);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = (which == 0) ? bus1.req_ready : bus4.req_ready;
      @(posedge clk); #1;
      n++;
    end
    set_req(which, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("xfer_accepted", {63'd0, acc}, 64'd1);
    done = 1'b0;
    n = 0;
    while (acc && !done && n < 20) begin
      if (which == 0 && bus1.rsp_valid && bus1.rsp_ready) begin rdata = bus1.rsp_rdata; done = 1'b1; end
      if (which != 0 && bus4.rsp_valid && bus4.rsp_ready) begin rdata = bus4.rsp_rdata; done = 1'b1; end
      @(posedge clk); #1;
      n++;
    end
    check("xfer_responded", {63'd0, done}, 64'd1);
  endtask

  task automatic rd32(input int which, input logic [31:0] a, output logic [31:0] rdata);
    bus_xfer(which, 1'b0, a, 32'd0, 4'd0, rdata);
  endtask

  task automatic wr32(input int which, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    bus_xfer(which, 1'b1, a, d, s, unused_rd);
  endtask

  task automatic wait_edge(input int k);
    int n;
    n = 0;
    while (m_cyc < k && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] rd, first4;
  int c0;

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus1.rsp_ready = 1'b1;
    bus4.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state (first cycle after the last reset edge; m_cyc == 0).
    check("rst_req_ready", {63'd0, bus1.req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, bus1.rsp_rdata}, 64'd0);
    check("rst_mtip", {63'd0, mtip1}, 64'd0);
    check("rst_msip", {63'd0, msip1}, 64'd0);
    check("rst_dbg_state", {63'd0, dbg1}, {63'd0, BUS_IDLE});
    check("rst_mtip4", {63'd0, mtip4}, 64'd0);

    // mtime counts one per edge after reset; a read accepted on edge 10 sees 9.
    wait_edge(9);
    rd32(0, 32'h0200_BFF8, rd);
    check("mtime_after_10", {32'd0, rd}, 64'd9);
    rd32(0, 32'h0200_4004, rd);
    check("mtimecmp_hi_rst", {32'd0, rd}, 64'hFFFF_FFFF);
    check("mtip_idle", {63'd0, mtip1}, 64'd0);

    // mtimecmp = 20: mtime reaches 20 on edge 20, mtip rises on edge 21.
    wr32(0, 32'h0200_4004, 32'd0, 4'hF);
    wr32(0, 32'h0200_4000, 32'd20, 4'hF);
    wait_edge(20);
    check("mtip_before_20", {63'd0, mtip1}, 64'd0);
    wait_edge(21);
    check("mtip_at_20", {63'd0, mtip1}, 64'd1);
    wr32(0, 32'h0200_4000, 32'hFFFF_FFFF, 4'hF);
    check("mtip_cleared", {63'd0, mtip1}, 64'd0);

    // Wrap: mtimecmp = 5, mtime = 2^64-2 on edge 28, wraps to 0 on edge 30.
    wr32(0, 32'h0200_4000, 32'd5, 4'hF);
    wr32(0, 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
    wr32(0, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF);
    check("mtip_pre_wrap", {63'd0, mtip1}, 64'd1);
    wait_edge(30);
    rd32(0, 32'h0200_BFF8, rd);
    check("mtime_lo_wrapped", {32'd0, rd}, 64'd0);
    rd32(0, 32'h0200_BFFC, rd);
    check("mtime_hi_wrapped", {32'd0, rd}, 64'd0);
    check("mtip_post_wrap", {63'd0, mtip1}, 64'd0);

    // Byte write on a tick cycle: 0x123456FF -> 0x123456AB, no carry into byte 1.
    wr32(0, 32'h0200_BFF8, 32'h1234_56FE, 4'hF);
    wr32(0, 32'h0200_BFF8, 32'h0000_00AB, 4'b0001);
    rd32(0, 32'h0200_BFF8, rd);
    check("mtime_byte_write", {32'd0, rd}, 64'h1234_56AC);
    rd32(0, 32'h0200_BFFC, rd);
    check("mtime_hi_kept", {32'd0, rd}, 64'd0);

    // Unmapped offset: read 0, writes ignored.
    wr32(0, 32'h0200_0008, 32'hFFFF_FFFF, 4'hF);
    rd32(0, 32'h0200_0008, rd);
    check("unmapped_read", {32'd0, rd}, 64'd0);

    // Software interrupt.
    wr32(0, 32'h0200_0000, 32'h0000_0001, 4'h1);
    check("msip_out", {63'd0, msip1}, {63'd0, MSIP_EXP});
    rd32(0, 32'h0200_0000, rd);
    check("msip_read", {32'd0, rd}, {63'd0, MSIP_EXP});

    // Response stall: held response stays put, a new request is not accepted.
    bus1.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0200_4004, 32'd0, 4'd0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h0200_4004, 32'h0000_0077, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd1);
      check("stall_rsp_rdata", {32'd0, bus1.rsp_rdata}, 64'd0);
      check("stall_req_ready", {63'd0, bus1.req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_released", {63'd0, bus1.rsp_valid}, 64'd0);
    rd32(0, 32'h0200_4004, rd);
    check("stall_write_dropped", {32'd0, rd}, 64'd0);

    // TICK_DIV=4 instance: mtime after edge k is k/4; 40 cycles later exactly +10.
    c0 = m_cyc;
    rd32(1, 32'h0200_BFF8, first4);
    check("div4_first", {32'd0, first4}, 64'(c0 / 4));
    wait_edge(c0 + 40);
    rd32(1, 32'h0200_BFF8, rd);
    check("div4_delta", {32'd0, rd - first4}, 64'd10);

    // Reset mid-transaction discards the pending response.
    bus1.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0200_BFF8, 32'd0, 4'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("midrst_pending", {63'd0, bus1.rsp_valid}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rsp_valid", {63'd0, bus1.rsp_valid}, 64'd0);
    check("midrst_req_ready", {63'd0, bus1.req_ready}, 64'd1);
    check("midrst_rsp_rdata", {32'd0, bus1.rsp_rdata}, 64'd0);
    check("midrst_mtip", {63'd0, mtip1}, 64'd0);
    bus1.rsp_ready = 1'b1;
    rd32(0, 32'h0200_BFF8, rd);
    check("midrst_mtime", {32'd0, rd}, 64'd0);
    rd32(0, 32'h0200_4004, rd);
    check("midrst_mtimecmp", {32'd0, rd}, 64'hFFFF_FFFF);
    check("midrst_msip", {63'd0, msip1}, 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/clint_timer.md
# clint_timer

Core-local interruptor for the RISC-V core. Holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit behind a memory-mapped slave port on the data-memory bus. Drives `mtip` (and `msip`) directly into the CSR unit, which exposes them as `mip[7]`/`mip[3]` and raises the timer interrupt.

## Interface
Parameters:
- `TICK_DIV`, 1: clk cycles per `mtime` increment; legal range 1..65535.
- `BASE_ADDR`, 32'h0200_0000: block base; block decodes a 64 KiB window.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  bus request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  32  byte address, word aligned; bits [1:0] ignored
- `req_wdata`  in  32  write data
- `req_wstrb`  in  4  byte enables for writes
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`
- `rsp_rdata`  out  32  read data; 0 for writes
- `mtip`  out  1  timer interrupt pending, to CSR
- `msip`  out  1  software interrupt pending, to CSR

## Operation
- Register map (offset from `BASE_ADDR`): 0x0000 `msip` (bit 0 only, others read 0); 0x4000 `mtimecmp[31:0]`; 0x4004 `mtimecmp[63:32]`; 0xBFF8 `mtime[31:0]`; 0xBFFC `mtime[63:32]`. Any other offset in the window: read 0, write ignored, response still returned.
- Writes honour `req_wstrb` per byte.
- Prescaler: down-counter loaded with `TICK_DIV-1`; when it reaches 0 it reloads and `mtime` increments by 1. With `TICK_DIV`=1, `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0; no carry-out.
- A bus write to either `mtime` half in a cycle where an increment is due: the write wins for the written bytes, the increment is dropped that cycle. The prescaler is not reset by `mtime` writes.
- `mtip` = registered (`mtime` >= `mtimecmp`), unsigned 64-bit compare on current register values.
- Bus FSM, two states. IDLE: `req_ready`=1. On accept, perform the access and go to RESP with `rsp_valid`=1. RESP: `req_ready`=0; hold `rsp_rdata` stable until `rsp_ready`, then return to IDLE. Back-to-back accepts are not supported: one outstanding request.
- Read data is captured in the accept cycle. A 64-bit read is two 32-bit accesses; software handles hi/lo tearing.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=`TICK_DIV-1`, FSM=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `mtip`=0.
- Request accepted in cycle N: register update visible in cycle N+1; `rsp_valid` high from cycle N+1.
- `mtip` reflects a compare condition one cycle after the registers reach it. A `mtimecmp` write that clears the condition in cycle N deasserts `mtip` in cycle N+2.
- Reset asserted mid-transaction: the pending response is discarded, `rsp_valid` drops on the next edge, and all registers return to reset values.

## Configuration
- `CLINT_MSIP_EN` defined: the `msip` register exists at 0x0000 and the `msip` output follows bit 0.
- `CLINT_MSIP_EN` undefined: no storage; offset 0x0000 reads 0 and ignores writes; `msip` is tied to 0.

## Structure
- Shared package `clint_pkg`: offset constants (`CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`) and the `mtimecmp` reset constant.
- One sub-module: `clint_prescaler`, which takes (`clk`, `rst`, parameter `TICK_DIV`) and outputs a single-cycle `tick` strobe.

## Test plan
- Reset, `TICK_DIV`=1, run 10 cycles, read 0xBFF8 -> value 9 or 10 (documented exact count); `mtip`=0, `rsp_rdata` of 0x4004 = 0xFFFF_FFFF.
- Write `mtimecmp`=20 (hi=0, then lo=20) -> `mtip` rises one cycle after `mtime` reaches 20; write `mtimecmp` lo=0xFFFF_FFFF -> `mtip` falls two cycles later.
- `TICK_DIV`=4: `mtime` increments exactly once every 4 cycles over 40 cycles (delta 10).
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE, wait 2 ticks -> reads 0; with `mtimecmp`=5, `mtip` deasserts after the wrap.
- Write 0xBFF8 with `wstrb`=4'b0001, data 0xAB, on a tick cycle -> low byte = 0xAB, other bytes unchanged, no increment that cycle.
- Hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0; with `CLINT_MSIP_EN`, write 0x0000=1 -> `msip`=1 next cycle; without the macro -> reads 0 and `msip`=0.
